if_id_queue: RTL and testbench

- Instruction queue between the fetch stage and decode.
- Buffers REG_IF_ID entries produced by fetch and presents them in order to decode through a valid/ready handshake.
- Back-pressures fetch through its bubble-hold input, and discards all buffered instructions on a pipeline flush (branch or jump redirect).

---
 rtl/if_id_queue_pkg.sv | 22 ++
 rtl/if_id_queue_if.sv | 36 +++
 rtl/if_id_queue_mem.sv | 36 +++
 rtl/if_id_queue.sv | 107 ++++++++++
 tb/tb_if_id_queue.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_queue_pkg
// Types shared between fetch, the IF/ID instruction queue and decode.
//   u64 / u32   : unsigned machine-word typedefs
//   PCINIT      : architectural reset PC
//   REG_IF_ID   : one fetched instruction (valid, pcPlus4, instr, instrAddr)
// -----------------------------------------------------------------------------
package if_id_queue_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   localparam u64 PCINIT = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic valid;
      u64   pcPlus4;
      u32   instr;
      u64   instrAddr;
   } REG_IF_ID;

endpackage

// File: rtl/if_id_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_queue_if
// Bundle of the fetch-side and decode-side signals of the IF/ID queue.
//   fetchIn     : entry from fetch (accepted when fetchIn.valid=1)
//   fetchHold   : bubble-hold back to fetch
//   flush       : pipeline redirect, discards everything queued
//   decReady    : decode accepts decOut this cycle
//   decOut      : head entry, decOut.valid=1 when non-empty
//   count       : occupancy 0..DEPTH
//   overflowErr : sticky, an entry arrived while full with no dequeue
// master = the pipeline around the queue, slave = the queue itself.
// -----------------------------------------------------------------------------
interface if_id_queue_if #(
   parameter int DEPTH = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   if_id_queue_pkg::REG_IF_ID fetchIn;
   logic                      fetchHold;
   logic                      flush;
   logic                      decReady;
   if_id_queue_pkg::REG_IF_ID decOut;
   logic [PTR_W:0]            count;
   logic                      overflowErr;

   modport master (
      output fetchIn, flush, decReady,
      input  fetchHold, decOut, count, overflowErr
   );

   modport slave (
      input  fetchIn, flush, decReady,
      output fetchHold, decOut, count, overflowErr
   );

endinterface

// File: rtl/if_id_queue_mem.sv
// -----------------------------------------------------------------------------
// if_id_queue_mem
// DEPTH x REG_IF_ID storage for the instruction queue. Not reset: the
// control logic never presents an entry that was not written first.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write slot
//   wdata_i  : entry to store
//   raddr_i  : read slot
//   rdata_o  : entry at raddr_i (asynchronous read)
// -----------------------------------------------------------------------------
module if_id_queue_mem
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  REG_IF_ID         wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output REG_IF_ID         rdata_o
);

   REG_IF_ID mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// In-order instruction queue between fetch and decode.
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset
//   q   : if_id_queue_if.slave (fetchIn, fetchHold, flush, decReady,
//         decOut, count, overflowErr)
// Full/empty are derived from the occupancy counter, never from the
// pointers. Flush overrides both enqueue and dequeue.
// -----------------------------------------------------------------------------
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   if_id_queue_if.slave q
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   HOLD_CNT = (PTR_W+1)'(DEPTH-1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflowErr_q, overflowErr_d;

   logic     notEmpty;
   logic     full;
   logic     enq;
   logic     deq;
   REG_IF_ID headEntry;
   REG_IF_ID decOut_c;

   assign notEmpty = (count_q != '0);
   assign full     = (count_q == FULL_CNT);

   // A dequeue in the same cycle frees the slot, so a full queue can still
   // accept an entry when decode is draining it.
   assign deq = notEmpty & q.decReady & ~q.flush;
   assign enq = q.fetchIn.valid & ~q.flush & (~full | deq);

   always_comb begin
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      count_d       = count_q;
      overflowErr_d = overflowErr_q;
      if (q.flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (enq) wrPtr_d = wrPtr_q + PTR_ONE;
         if (deq) rdPtr_d = rdPtr_q + PTR_ONE;
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         // Entry arriving at a full queue with nobody draining is lost.
         if (q.fetchIn.valid & full & ~deq) overflowErr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         overflowErr_q <= 1'b0;
      end else begin
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         overflowErr_q <= overflowErr_d;
      end
   end

   if_id_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (enq),
      .waddr_i (wrPtr_q),
      .wdata_i (q.fetchIn),
      .raddr_i (rdPtr_q),
      .rdata_o (headEntry)
   );

   // Stored slots may hold stale data; validity comes only from occupancy.
   always_comb begin
      decOut_c       = headEntry;
      decOut_c.valid = notEmpty;
   end

   assign q.decOut      = decOut_c;
   assign q.count       = count_q;
   // Threshold at DEPTH-1 leaves room for the entry fetch already has in flight.
   assign q.fetchHold   = (count_q >= HOLD_CNT);
   assign q.overflowErr = overflowErr_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
   import if_id_queue_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   if_id_queue_if #(.DEPTH(DEPTH)) bus ();

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: an ordered list of accepted entries plus the sticky flag.
   REG_IF_ID mq[$];
   bit       m_ovf = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
   endtask

   // Queue semantics: flush empties, decode takes the head if ready,
   // fetch appends if there is (or will be) room, otherwise it is lost.
   task automatic model_edge();
      bit take;
      bit room;
      if (bus.flush) begin
         mq.delete();
      end else begin
         take = (mq.size() > 0) && bus.decReady;
         room = (mq.size() < DEPTH) || take;
         if (bus.fetchIn.valid && !room) m_ovf = 1'b1;
         if (take) void'(mq.pop_front());
         if (bus.fetchIn.valid && room) mq.push_back(bus.fetchIn);
      end
   endtask

   task automatic compare();
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("dec_valid", 64'(bus.decOut.valid), 64'(mq.size() != 0));
      chk("fetch_hold", 64'(bus.fetchHold), 64'(mq.size() >= DEPTH - 1));
      chk("overflow", 64'(bus.overflowErr), 64'(m_ovf));
      if (mq.size() != 0) begin
         chk("head_addr", bus.decOut.instrAddr, mq[0].instrAddr);
         chk("head_instr", 64'(bus.decOut.instr), 64'(mq[0].instr));
         chk("head_pc4", bus.decOut.pcPlus4, mq[0].pcPlus4);
      end
   endtask

   // One clock: model follows the same edge, outputs compared 2 ns later.
   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      #2;
      compare();
   endtask

   task automatic drive(input bit v, input u64 addr, input u32 ins, input bit rdy, input bit fl);
      bus.fetchIn.valid     = v;
      bus.fetchIn.instrAddr = addr;
      bus.fetchIn.pcPlus4   = addr + 64'd4;
      bus.fetchIn.instr     = ins;
      bus.decReady          = rdy;
      bus.flush             = fl;
   endtask

   initial begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      model_reset();

      // Reset held for three cycles, then idle.
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_valid", 64'(bus.decOut.valid), 64'd0);
      chk("rst_hold", 64'(bus.fetchHold), 64'd0);
      chk("rst_ovf", 64'(bus.overflowErr), 64'd0);
      step();

      // Streaming with decode always ready: one in, one out per cycle.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, PCINIT + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b1, 1'b0);
         step();
         chk("stream_addr", bus.decOut.instrAddr, PCINIT + 64'(4 * i));
         chk("stream_count", 64'(bus.count), 64'd1);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      chk("stream_empty", 64'(bus.count), 64'd0);

      // Backpressure: three entries raise hold, the in-flight fourth fits.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'h8000_0010 + 64'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
         step();
         if (i == 2) begin
            chk("bp_count3", 64'(bus.count), 64'd3);
            chk("bp_hold3", 64'(bus.fetchHold), 64'd1);
         end
      end
      chk("bp_count4", 64'(bus.count), 64'd4);
      chk("bp_ovf", 64'(bus.overflowErr), 64'd0);
      chk("bp_head", bus.decOut.instrAddr, 64'h8000_0010);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      chk("drain_hold3", 64'(bus.fetchHold), 64'd1);
      step();
      chk("drain_count2", 64'(bus.count), 64'd2);
      chk("drain_hold2", 64'(bus.fetchHold), 64'd0);
      chk("drain_head", bus.decOut.instrAddr, 64'h8000_0018);
      repeat (2) step();

      // Fill, then enqueue and dequeue together while full.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'h8000_0040 + 64'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 64'h8000_0050, 32'h2000_0004, 1'b1, 1'b0);
      step();
      chk("full_sim_count", 64'(bus.count), 64'd4);
      chk("full_sim_head", bus.decOut.instrAddr, 64'h8000_0044);
      chk("full_sim_ovf", 64'(bus.overflowErr), 64'd0);

      // Overflow: full, decode stalled, one more arrives and is lost.
      drive(1'b1, 64'h8000_0060, 32'hDEAD_BEEF, 1'b0, 1'b0);
      step();
      chk("ovf_count", 64'(bus.count), 64'd4);
      chk("ovf_flag", 64'(bus.overflowErr), 64'd1);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_instr_ne", 64'(bus.decOut.instr == 32'hDEAD_BEEF), 64'd0);
         step();
      end
      chk("ovf_sticky", 64'(bus.overflowErr), 64'd1);

      // Flush with two queued and an arriving entry.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 64'h8000_0080 + 64'(4 * i), 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
         step();
      end
      chk("pre_flush_count", 64'(bus.count), 64'd2);
      drive(1'b1, 64'h8000_0090, 32'h3000_0009, 1'b0, 1'b1);
      step();
      chk("flush_count", 64'(bus.count), 64'd0);
      chk("flush_valid", 64'(bus.decOut.valid), 64'd0);
      chk("flush_hold", 64'(bus.fetchHold), 64'd0);
      drive(1'b1, 64'h8000_0100, 32'h0000_0033, 1'b0, 1'b0);
      step();
      chk("post_flush_head", bus.decOut.instrAddr, 64'h8000_0100);
      chk("post_flush_count", 64'(bus.count), 64'd1);

      // Asynchronous reset between edges clears occupancy and the flag.
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      chk("async_rst_count", 64'(bus.count), 64'd0);
      chk("async_rst_ovf", 64'(bus.overflowErr), 64'd0);
      chk("async_rst_valid", 64'(bus.decOut.valid), 64'd0);
      step();
      rst = 1'b1;

      // Randomized traffic, with one mid-run asynchronous reset.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0,
               {32'h0, $urandom()},
               $urandom(),
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 19) == 0);
         if (n == 1500) begin
            #4;
            rst = 1'b0;
            model_reset();
            #1;
            chk("rand_rst_count", 64'(bus.count), 64'd0);
            step();
            rst = 1'b1;
         end else begin
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
